ahblite_cmd_master: RTL and testbench

AHB-Lite initiator that converts a simple valid/ready command stream (single reads and writes) into pipelined AHB-Lite SINGLE transfers, and returns one registered response per command. It is the bus-master counterpart of the block-RAM and peripheral slaves. It lets non-CPU logic (loaders, test engines) reach the slave address map through the bus matrix.

---
 rtl/ahb_pkg.sv | 55 +++++
 rtl/ahblite_cmd_master_if.sv | 46 ++++
 rtl/ahblite_lane_mux.sv | 48 ++++
 rtl/ahblite_cmd_master.sv | 140 ++++++++++++++
 tb/tb_ahblite_cmd_master.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slot record types and small helper functions
// used by the command master and its lane multiplexer.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;

  localparam logic [2:0] HSIZE_BYTE      = 3'b000;
  localparam logic [2:0] HSIZE_HALF      = 3'b001;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  // Address-phase slot: everything needed to drive one address phase
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } a_slot_t;

  // Data-phase slot: only the low address bits matter for lane selection
  typedef struct packed {
    logic        valid;
    logic [1:0]  addr_lo;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } d_slot_t;

  // Command size code to HSIZE; code 3 is treated as a word
  function automatic logic [2:0] cmd_to_hsize(input logic [1:0] cmd_size);
    logic [2:0] hsize;
    case (cmd_size)
      2'd0:    hsize = HSIZE_BYTE;
      2'd1:    hsize = HSIZE_HALF;
      default: hsize = HSIZE_WORD;
    endcase
    return hsize;
  endfunction

  // Force natural alignment of an address for the given transfer size
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [2:0] hsize);
    logic [31:0] aligned;
    case (hsize)
      HSIZE_WORD: aligned = {addr[31:2], 2'b00};
      HSIZE_HALF: aligned = {addr[31:1], 1'b0};
      default:    aligned = addr;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/ahblite_cmd_master_if.sv
// Bundle of the command stream, response stream and AHB-Lite master bus.
// The master modport is the command master's view; slave is the far side
// (command producer plus the addressed AHB slave).
interface ahblite_cmd_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    input  HRDATA, HREADY, HRESP,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_err, rsp_rdata,
    output HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
    output HRDATA, HREADY, HRESP,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_err, rsp_rdata,
    input  HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

endinterface

// File: rtl/ahblite_lane_mux.sv
// Byte-lane steering: replicates right-justified write data onto every lane
// of its size, and extracts/zero-extends the addressed lane of read data.
module ahblite_lane_mux
  import ahb_pkg::*;
(
  input  logic [2:0]  wsize,
  input  logic [31:0] wdata,
  input  logic [2:0]  rsize,
  input  logic [1:0]  raddr_lo,
  input  logic [31:0] rdata_in,
  output logic [31:0] hwdata,
  output logic [31:0] rdata_out
);

  // Write-lane replication so any byte/half lane sees the data
  always_comb begin
    hwdata = 32'h0000_0000;
    case (wsize)
      HSIZE_BYTE: hwdata = {4{wdata[7:0]}};
      HSIZE_HALF: hwdata = {2{wdata[15:0]}};
      default:    hwdata = wdata;
    endcase
  end

  // Read-lane extraction, zero-extended and right-justified
  always_comb begin
    rdata_out = 32'h0000_0000;
    case (rsize)
      HSIZE_BYTE: begin
        case (raddr_lo)
          2'd0:    rdata_out = {24'h00_0000, rdata_in[7:0]};
          2'd1:    rdata_out = {24'h00_0000, rdata_in[15:8]};
          2'd2:    rdata_out = {24'h00_0000, rdata_in[23:16]};
          default: rdata_out = {24'h00_0000, rdata_in[31:24]};
        endcase
      end
      HSIZE_HALF: begin
        if (raddr_lo[1]) begin
          rdata_out = {16'h0000, rdata_in[31:16]};
        end else begin
          rdata_out = {16'h0000, rdata_in[15:0]};
        end
      end
      default: rdata_out = rdata_in;
    endcase
  end

endmodule

// File: rtl/ahblite_cmd_master.sv
// AHB-Lite initiator: turns a valid/ready command stream of single reads and
// writes into pipelined SINGLE transfers through an address slot (A) and a
// data slot (D), returning one registered response per command in order.
// A two-cycle ERROR cancels the pending address phase and re-issues it.
module ahblite_cmd_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahblite_cmd_master_if.master bus
);

  // Bits of HADDR above ADDR_WIDTH are tied low
  localparam logic [31:0] ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << ADDR_WIDTH) - 32'd1);

  a_slot_t     a_r;
  d_slot_t     d_r;
  logic        err_cancel_r;
  logic        rsp_valid_r;
  logic        rsp_write_r;
  logic        rsp_err_r;
  logic [31:0] rsp_rdata_r;

  logic        advance_s;
  logic        cmd_ready_s;
  logic        accept_s;
  logic        err_start_s;
  logic        err_done_s;
  logic        rsp_fire_s;
  logic [2:0]  cmd_hsize_s;
  a_slot_t     cmd_slot_s;
  logic [31:0] hwdata_s;
  logic [31:0] rdata_ext_s;

  // Pipeline advance, handshake and error-phase decode
  always_comb begin
    advance_s   = bus.HREADY & ~err_cancel_r;
    cmd_ready_s = ~a_r.valid | advance_s;
    accept_s    = bus.cmd_valid & cmd_ready_s;
    err_start_s = d_r.valid & bus.HRESP & ~bus.HREADY;
    err_done_s  = err_cancel_r & bus.HREADY;
    rsp_fire_s  = d_r.valid & bus.HREADY;
  end

  // Build the address-slot image of the incoming command (size-aligned)
  always_comb begin
    cmd_hsize_s      = cmd_to_hsize(bus.cmd_size);
    cmd_slot_s.valid = 1'b1;
    cmd_slot_s.addr  = align_addr(bus.cmd_addr & ADDR_MASK, cmd_hsize_s);
    cmd_slot_s.write = bus.cmd_write;
    cmd_slot_s.size  = cmd_hsize_s;
    cmd_slot_s.wdata = bus.cmd_wdata;
  end

  // Slot pipeline: advance on a clean ready edge, otherwise freeze; an
  // empty A may load even while the bus is stalled or cancelling
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_r <= '0;
      d_r <= '0;
    end else if (advance_s) begin
      d_r.valid   <= a_r.valid;
      d_r.addr_lo <= a_r.addr[1:0];
      d_r.write   <= a_r.write;
      d_r.size    <= a_r.size;
      d_r.wdata   <= a_r.wdata;
      if (accept_s) begin
        a_r <= cmd_slot_s;
      end else begin
        a_r.valid <= 1'b0;
      end
    end else begin
      if (err_done_s) begin
        d_r.valid <= 1'b0;
      end
      if (accept_s) begin
        a_r <= cmd_slot_s;
      end
    end
  end

  // Error cancel flag spans the gap between the two ERROR cycles
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_cancel_r <= 1'b0;
    end else if (err_start_s) begin
      err_cancel_r <= 1'b1;
    end else if (err_done_s) begin
      err_cancel_r <= 1'b0;
    end
  end

  // One registered response pulse per completed data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else if (rsp_fire_s) begin
      rsp_valid_r <= 1'b1;
      rsp_write_r <= d_r.write;
      rsp_err_r   <= bus.HRESP;
      rsp_rdata_r <= d_r.write ? 32'h0000_0000 : rdata_ext_s;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end
  end

  ahblite_lane_mux u_lane_mux (
    .wsize     (d_r.size),
    .wdata     (d_r.wdata),
    .rsize     (d_r.size),
    .raddr_lo  (d_r.addr_lo),
    .rdata_in  (bus.HRDATA),
    .hwdata    (hwdata_s),
    .rdata_out (rdata_ext_s)
  );

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.HTRANS    = (a_r.valid & ~err_cancel_r) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = a_r.addr;
  assign bus.HSIZE     = a_r.size;
  assign bus.HWRITE    = a_r.write;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_DATA_PRIV;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = hwdata_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_write = rsp_write_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_ahblite_cmd_master.sv
// Directed bench for ahblite_cmd_master with a small AHB memory slave
// (programmable wait states and a two-cycle ERROR address) and a response
// scoreboard fed at issue time and drained by an independent monitor.
module tb_ahblite_cmd_master;
  import ahb_pkg::*;

  logic clk;
  logic rst;

  ahblite_cmd_master_if bus ();

  ahblite_cmd_master #(.ADDR_WIDTH(32)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        write;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- AHB memory slave model ----------------
  logic [31:0] mem [0:63];
  logic        dp_valid;
  logic        dp_write;
  logic        dp_err;
  logic        err_stage;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;
  int          wait_left;
  int          waits_cfg;
  logic        err_en;
  logic [31:0] err_addr;
  logic        hready_s;
  logic        hresp_s;
  logic [31:0] hrdata_s;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] lo, input logic [2:0] size);
    logic [31:0] r;
    r = old;
    case (size)
      HSIZE_BYTE: r[8*lo +: 8] = wd[8*lo +: 8];
      HSIZE_HALF: r[16*lo[1] +: 16] = wd[16*lo[1] +: 16];
      default:    r = wd;
    endcase
    return r;
  endfunction

  // Slave data-phase outputs
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    hrdata_s = 32'h0000_0000;
    if (dp_valid) begin
      if (wait_left != 0) begin
        hready_s = 1'b0;
      end else if (dp_err) begin
        hresp_s  = 1'b1;
        hready_s = err_stage;
      end else begin
        hready_s = 1'b1;
      end
      if (!dp_write && !dp_err) hrdata_s = mem[dp_addr[7:2]];
    end
  end

  assign bus.HREADY = hready_s;
  assign bus.HRESP  = hresp_s;
  assign bus.HRDATA = hrdata_s;

  // Slave address capture and data-phase sequencing
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_err    <= 1'b0;
      err_stage <= 1'b0;
      dp_addr   <= 32'h0;
      dp_size   <= 3'b000;
      wait_left <= 0;
    end else begin
      if (dp_valid) begin
        if (wait_left != 0) wait_left <= wait_left - 1;
        else if (dp_err && !err_stage) err_stage <= 1'b1;
        else dp_valid <= 1'b0;
      end
      if (hready_s && bus.HTRANS == HTRANS_NONSEQ) begin
        dp_valid  <= 1'b1;
        dp_addr   <= bus.HADDR;
        dp_write  <= bus.HWRITE;
        dp_size   <= bus.HSIZE;
        wait_left <= waits_cfg;
        dp_err    <= err_en && (bus.HADDR == err_addr);
        err_stage <= 1'b0;
      end
    end
  end

  // Slave memory update on a completed, non-error write data phase
  always @(posedge clk) begin
    if (!rst && dp_valid && hready_s && dp_write && !dp_err) begin
      mem[dp_addr[7:2]] <= merge(mem[dp_addr[7:2]], bus.HWDATA, dp_addr[1:0], dp_size);
    end
  end

  // ---------------- response monitor ----------------
  rsp_t got_e;
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
      end else begin
        got_e = exp_q.pop_front();
        check("rsp_write", {31'h0, bus.rsp_write}, {31'h0, got_e.write});
        check("rsp_err",   {31'h0, bus.rsp_err},   {31'h0, got_e.err});
        check("rsp_rdata", bus.rsp_rdata, got_e.rdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_write = 1'b0;
    bus.cmd_size  = 2'd0;
    bus.cmd_wdata = 32'h0;
  endtask

  // Present one command, record its expected response, return one tick
  // after the accepting edge with cmd_valid still asserted
  task automatic issue(input logic [31:0] addr, input logic write, input logic [1:0] size,
                       input logic [31:0] wdata, input logic track,
                       input logic exp_err, input logic [31:0] exp_rdata);
    int   n;
    rsp_t e;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_write = write;
    bus.cmd_size  = size;
    bus.cmd_wdata = wdata;
    if (track) begin
      e.write = write;
      e.err   = exp_err;
      e.rdata = exp_rdata;
      exp_q.push_back(e);
    end
    while (bus.cmd_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 40 cycles expected 1 at %0t", $time);
    end
    step();
  endtask

  task automatic drain(input int cycles);
    idle();
    for (int i = 0; i < cycles; i++) step();
  endtask

  logic [31:0] byte_val [4];
  logic [31:0] byte_rep [4];

  // ---------------- directed sequence ----------------
  initial begin
    rst       = 1'b1;
    waits_cfg = 0;
    err_en    = 1'b0;
    err_addr  = 32'h0;
    byte_val  = '{32'h11, 32'h22, 32'h33, 32'h44};
    byte_rep  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    idle();
    step();

    // Reset state
    check("rst_htrans",    {30'h0, bus.HTRANS}, {30'h0, HTRANS_IDLE});
    check("rst_haddr",     bus.HADDR, 32'h0);
    check("rst_hsize",     {29'h0, bus.HSIZE}, 32'h0);
    check("rst_hwrite",    {31'h0, bus.HWRITE}, 32'h0);
    check("rst_hwdata",    bus.HWDATA, 32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("hburst",        {29'h0, bus.HBURST}, 32'h0);
    check("hprot",         {28'h0, bus.HPROT}, 32'h3);
    check("hmastlock",     {31'h0, bus.HMASTLOCK}, 32'h0);
    rst = 1'b0;
    step();

    // Word write then read, with zero-wait latency checks
    issue(32'h10, 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    idle();
    check("wr_htrans",  {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
    check("wr_haddr",   bus.HADDR, 32'h10);
    check("wr_hwrite",  {31'h0, bus.HWRITE}, 32'h1);
    check("wr_hsize",   {29'h0, bus.HSIZE}, {29'h0, HSIZE_WORD});
    step();
    check("wr_hwdata",  bus.HWDATA, 32'hDEAD_BEEF);
    check("wr_rsp_early", {31'h0, bus.rsp_valid}, 32'h0);
    step();
    check("wr_rsp_n3",  {31'h0, bus.rsp_valid}, 32'h1);
    issue(32'h10, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    drain(6);

    // Back-to-back byte writes, then word and sub-word reads
    for (int k = 0; k < 4; k++) begin
      issue(32'h20 + k, 1'b1, 2'd0, byte_val[k], 1'b1, 1'b0, 32'h0);
      check("b2b_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
      check("b2b_haddr", bus.HADDR, 32'h20 + k);
      if (k > 0) check("b2b_hwdata", bus.HWDATA, byte_rep[k-1]);
    end
    idle();
    step();
    check("b2b_hwdata_last", bus.HWDATA, byte_rep[3]);
    drain(4);
    issue(32'h20, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'h4433_2211);
    issue(32'h23, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0000_0044);
    issue(32'h22, 1'b0, 2'd1, 32'h0, 1'b1, 1'b0, 32'h0000_4433);
    drain(6);

    // Half read with three wait states, second read queued during the stall
    issue(32'h30, 1'b1, 2'd3, 32'hABCD_0000, 1'b1, 1'b0, 32'h0);
    drain(5);
    waits_cfg = 3;
    issue(32'h32, 1'b0, 2'd1, 32'h0, 1'b1, 1'b0, 32'h0000_ABCD);
    idle();
    check("ws_haddr",  bus.HADDR, 32'h32);
    check("ws_hsize",  {29'h0, bus.HSIZE}, {29'h0, HSIZE_HALF});
    step();
    waits_cfg = 0;
    check("ws_htrans_idle", {30'h0, bus.HTRANS}, {30'h0, HTRANS_IDLE});
    check("ws_ready_empty", {31'h0, bus.cmd_ready}, 32'h1);
    issue(32'h10, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    idle();
    for (int i = 0; i < 3; i++) begin
      check("ws_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
      check("ws_haddr_hold", bus.HADDR, 32'h10);
      check("ws_rsp_hold", {31'h0, bus.rsp_valid}, 32'h0);
      check("ws_cmd_ready", {31'h0, bus.cmd_ready}, (i < 2) ? 32'h0 : 32'h1);
      step();
    end
    check("ws_rsp_late", {31'h0, bus.rsp_valid}, 32'h1);
    drain(6);

    // Two-cycle ERROR on the first of two pipelined reads
    err_en   = 1'b1;
    err_addr = 32'h40;
    issue(32'h40, 1'b0, 2'd2, 32'h0, 1'b1, 1'b1, 32'h0);
    issue(32'h10, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    idle();
    check("err1_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
    check("err1_ready",  {31'h0, bus.cmd_ready}, 32'h0);
    step();
    check("err2_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_IDLE});
    check("err2_ready",  {31'h0, bus.cmd_ready}, 32'h0);
    step();
    check("reissue_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
    check("reissue_haddr",  bus.HADDR, 32'h10);
    check("err_rsp_valid",  {31'h0, bus.rsp_valid}, 32'h1);
    drain(6);
    err_en = 1'b0;

    // Reset while a read is in its data phase and another is pending
    issue(32'h10, 1'b0, 2'd2, 32'h0, 1'b0, 1'b0, 32'h0);
    issue(32'h20, 1'b0, 2'd2, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    check("prerst_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_NONSEQ});
    rst = 1'b1;
    #1;
    check("rst_mid_htrans", {30'h0, bus.HTRANS}, {30'h0, HTRANS_IDLE});
    check("rst_mid_ready",  {31'h0, bus.cmd_ready}, 32'h1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("postrst_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      check("postrst_ready", {31'h0, bus.cmd_ready}, 32'h1);
      step();
    end

    // Misaligned word read is aligned down
    issue(32'h13, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    idle();
    check("mis_haddr", bus.HADDR, 32'h10);
    check("mis_hsize", {29'h0, bus.HSIZE}, {29'h0, HSIZE_WORD});
    drain(6);

    check("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
